// File: rtl/module_seg7_scan_driver_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment order is abcdefg, with a in bit 6 and g in bit 0.
package pkg_seg7;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;

    // Full hex glyph set; lowercase b and d keep them distinct from 8 and 0.
    localparam seg_t HEX_SEG [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

endpackage

// File: rtl/module_seg7_scan_driver_hex_decoder.sv
// Combinational nibble-to-segment decoder, using the shared hex glyph table.
module module_seg7_hex_decoder
    import pkg_seg7::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/module_seg7_scan_driver.sv
// Multiplexed N-digit hex seven-segment driver with a double-buffered, tear-free update.
// The optional define LEADING_ZERO_BLANK_EN blanks the leading zero digits.
module module_seg7_scan_driver
    import pkg_seg7::*;
#(
    parameter int NDIGITS     = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*NDIGITS-1:0]   data_i,
    input  logic [NDIGITS-1:0]     dp_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [6:0]             seg_o,
    output logic                   dp_o,
    output logic [NDIGITS-1:0]     an_o
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [4*NDIGITS-1:0]   disp_data, shadow_data;
    logic [NDIGITS-1:0]     disp_dp, shadow_dp;
    logic                   pending;

    logic                   tick, wrap, xfer;
    logic [3:0]             sel_nib;
    logic                   sel_dp;
    logic [6:0]             dec_seg;
    logic                   blank;

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);
    assign xfer = valid_i && ready_o;

    always_comb begin
        sel_nib = 4'h0;
        sel_dp  = 1'b0;
        for (int k = 0; k < NDIGITS; k++) begin
            if (idx == IW'(k)) begin
                sel_nib = disp_data[4*k +: 4];
                sel_dp  = disp_dp[k];
            end
        end
    end

    module_seg7_hex_decoder u_dec (
        .nib (sel_nib),
        .seg (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        blank = (idx != '0);
        for (int k = 0; k < NDIGITS; k++) begin
            if ((IW'(k) >= idx) && (disp_data[4*k +: 4] != 4'h0))
                blank = 1'b0;
        end
    end
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            disp_data   <= '0;
            disp_dp     <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            pending     <= 1'b0;
            ready_o     <= 1'b1;
            seg_o       <= SEG_BLANK;
            dp_o        <= 1'b0;
            an_o        <= '1;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

            // ready_o is low whenever pending is set, so a transfer never meets a commit.
            if (xfer) begin
                shadow_data <= data_i;
                shadow_dp   <= dp_i;
                pending     <= 1'b1;
                ready_o     <= 1'b0;
            end else if (wrap && pending) begin
                disp_data <= shadow_data;
                disp_dp   <= shadow_dp;
                pending   <= 1'b0;
                ready_o   <= 1'b1;
            end

            seg_o <= blank ? SEG_BLANK : dec_seg;
            dp_o  <= sel_dp & ~blank;
            an_o  <= ~(NDIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_module_seg7_scan_driver.sv
// Directed scoreboard bench for module_seg7_scan_driver with NDIGITS=4 and REFRESH_DIV=4.
module tb_module_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_i = '0;
    logic [3:0]  dp_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;

    int tests = 0;
    int fails = 0;
    bit drop_valid = 1'b0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;
    exp_t q[$];

    logic [6:0] tbl [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    module_seg7_scan_driver #(.NDIGITS(4), .REFRESH_DIV(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .dp_i    (dp_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .seg_o   (seg_o),
        .dp_o    (dp_o),
        .an_o    (an_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t exp_entry(input logic [15:0] d, input logic [3:0] p, input int k);
        exp_t e;
        logic [15:0] upper;
        e.an  = ~(4'b0001 << k);
        e.seg = tbl[d[4*k +: 4]];
        e.dp  = p[k];
        upper = d >> (4*k);
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && upper == 16'h0) begin
            e.seg = 7'b0;
            e.dp  = 1'b0;
        end
`endif
        return e;
    endfunction

    task automatic push_frame(input logic [15:0] d, input logic [3:0] p);
        for (int k = 0; k < 4; k++) q.push_back(exp_entry(d, p, k));
    endtask

    // Called on a negedge with ready_o high; the transfer lands on the next posedge.
    task automatic load(input logic [15:0] d, input logic [3:0] p);
        data_i  = d;
        dp_i    = p;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        chk("ready_drop", {15'b0, ready_o}, 16'h0);
        push_frame(d, p);
    endtask

    task automatic wait_an(input logic [3:0] target);
        int n = 0;
        while (an_o !== target && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_an_timeout", {15'b0, (n < 100)}, 16'h1);
    endtask

    // Aligns on ready_o rising (cycle after commit), then checks one frame.
    task automatic sample_frame(input string tag);
        int n = 0;
        exp_t e;
        while (ready_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_timeout"}, {15'b0, (n < 200)}, 16'h1);
        chk({tag, "_an_at_ready"}, {12'b0, an_o}, 16'h7);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) @(negedge clk);
            else repeat (4) @(negedge clk);
            if (k == 0 && drop_valid) valid_i = 1'b0;
            if (q.size() == 0) begin
                chk({tag, "_queue_empty"}, 16'h1, 16'h0);
            end else begin
                e = q.pop_front();
                chk({tag, "_an"},  {12'b0, an_o},  {12'b0, e.an});
                chk({tag, "_seg"}, {9'b0, seg_o},  {9'b0, e.seg});
                chk({tag, "_dp"},  {15'b0, dp_o},  {15'b0, e.dp});
            end
        end
    endtask

    initial begin
        exp_t e;
        int   k;
        // Reset
        repeat (3) @(negedge clk);
        chk("rst_an",    {12'b0, an_o},   16'hF);
        chk("rst_seg",   {9'b0, seg_o},   16'h0);
        chk("rst_dp",    {15'b0, dp_o},   16'h0);
        chk("rst_ready", {15'b0, ready_o}, 16'h1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_an",  {12'b0, an_o},  16'hE);
        chk("first_seg", {9'b0, seg_o},  16'h007E);

        // Mid-frame load: old digits stay until the wrap
        repeat (5) @(negedge clk);
        load(16'h1234, 4'b0000);
        wait_an(4'b0111);
        chk("still_zero_seg", {9'b0, seg_o}, 16'h007E);
        chk("pending_ready",  {15'b0, ready_o}, 16'h0);
        sample_frame("f1234");

        // Hex letters with a decimal point
        load(16'hABCF, 4'b0001);
        sample_frame("fABCF");

        // Back-to-back: second value waits for ready_o
        data_i  = 16'h1111;
        dp_i    = 4'b0000;
        valid_i = 1'b1;
        @(negedge clk);
        push_frame(16'h1111, 4'b0000);
        data_i = 16'h2222;
        push_frame(16'h2222, 4'b0000);
        chk("b2b_ready_low", {15'b0, ready_o}, 16'h0);
        drop_valid = 1'b1;
        sample_frame("f1111");
        drop_valid = 1'b0;
        chk("b2b_second_pending", {15'b0, ready_o}, 16'h0);
        sample_frame("f2222");

        // Leading-zero patterns (blanked only when the define is set)
        load(16'h0070, 4'b0000);
        sample_frame("f0070");
        load(16'h0000, 4'b0000);
        sample_frame("f0000");

        // Reset with a value pending: it must never show
        load(16'h5678, 4'b1111);
        q.delete();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2_ready", {15'b0, ready_o}, 16'h1);
        chk("rst2_an",    {12'b0, an_o},    16'hF);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("post_rst_onehot", {15'b0, ($countones(~an_o) == 1)}, 16'h1);
            k = 0;
            for (int i = 0; i < 4; i++) if (an_o[i] == 1'b0) k = i;
            e = exp_entry(16'h0000, 4'b0000, k);
            chk("post_rst_seg",   {9'b0, seg_o},   {9'b0, e.seg});
            chk("post_rst_dp",    {15'b0, dp_o},   16'h0);
            chk("post_rst_ready", {15'b0, ready_o}, 16'h1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/module_seg7_scan_driver.md
# module_seg7_scan_driver

Multiplexed N-digit seven-segment display driver: accepts a packed hexadecimal value through a valid/ready handshake, double-buffers it, and time-multiplexes one digit at a time onto shared segment lines with one-hot active-low digit enables. Decodes full hex 0–F, not just 0–9. Supports per-digit decimal points and tear-free updates, with new values committed only at frame boundaries. Sits between the datapath registers and the board's display pins.

## Interface
- NDIGITS, 4, number of digits scanned (≥1)
- REFRESH_DIV, 50000, clock cycles each digit is lit (≥2)

- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  synchronous, active-low reset
- data_i  in  4*NDIGITS  packed nibbles; nibble k (bits 4k+3:4k) drives digit k, digit 0 rightmost
- dp_i  in  NDIGITS  decimal-point enables, bit k for digit k
- valid_i  in  1  data_i/dp_i valid
- ready_o  out  1  block can accept a new value
- seg_o  out  7  segments, active-high, order [6]=a … [0]=g
- dp_o  out  1  decimal point of the lit digit, active-high
- an_o  out  NDIGITS  digit enables, one-hot active-low

## Operation
- Prescaler `cnt` counts 0..REFRESH_DIV-1 and wraps. `tick` = (cnt == REFRESH_DIV-1).
- Digit index `idx` advances by 1 on `tick`, mod NDIGITS.
- Frame end `wrap` = tick && idx == NDIGITS-1. With NDIGITS=1, every tick is a wrap.
- Handshake:
  - Transfer occurs when valid_i && ready_o.
  - On transfer: shadow ← {data_i, dp_i}, pending ← 1, ready_o ← 0.
  - valid_i while ready_o=0 is ignored. The source must hold valid_i until ready_o.
- Commit: on wrap with pending=1, display ← shadow, pending ← 0, ready_o ← 1.
- Transfer and wrap in the same cycle with pending=0: the new data becomes pending and commits at the following wrap.
- Decode uses the hex table (abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Output registers:
  - seg_o ← decode(display nibble idx)
  - dp_o ← display dp bit idx
  - an_o ← ~(1 << idx)
- Widths: cnt is $clog2(REFRESH_DIV) bits; idx is max(1, $clog2(NDIGITS)) bits. Index comparisons use full width, with no truncation.

## Timing
- Reset values: cnt=0, idx=0, display=0, shadow=0, pending=0, ready_o=1, seg_o=0, dp_o=0, an_o all ones.
- Reset asserted mid-operation: any pending value is discarded and the display returns to 0.
- Output latency: seg_o/dp_o/an_o lag idx by exactly 1 cycle. The first cycle after reset release shows digit 0 with value 0.
- Each digit is lit for REFRESH_DIV cycles. A frame lasts NDIGITS*REFRESH_DIV cycles.
- Transfer to visible update: commits at the next wrap, then appears on outputs 1 cycle later.
- ready_o rises the cycle after the commit.
- an_o never has more than one bit low.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digits above the most significant non-zero nibble of display output seg_o=0 and dp_o=0.
  - an_o is unchanged, so scan timing is identical.
  - Digit 0 is never blanked.
- LEADING_ZERO_BLANK_EN undefined: all digits are always shown.

## Structure
- Package `pkg_seg7` holds:
  - the 7-bit segment typedef
  - the 16-entry hex segment constant table
  - the blank constant 7'b0
- Sub-module `module_seg7_hex_decoder` is purely combinational: 4-bit nibble in, 7-bit segments out, using the package table. The driver instantiates it once, on the selected nibble.

## Test plan
Bench uses NDIGITS=4, REFRESH_DIV=4.
- Reset: hold rst_n=0 for 3 cycles → an_o=1111, seg_o=0, ready_o=1. First cycle after release → an_o=1110, seg_o=1111110.
- Load 16'h1234 mid-frame → ready_o=0 next cycle and digits still show 0 until wrap. Next frame: digit0=0110011, digit1=1111001, digit2=1101101, digit3=0110000. ready_o=1 the cycle after commit.
- Hex and dp: load 16'hAbCF with dp_i=4'b0001 → digit0=1000111 with dp_o=1, digit3=1110111 with dp_o=0.
- Back-to-back: valid_i held with 16'h1111 then 16'h2222 → second transfer occurs only after ready_o rises. Frames show 1111, then 2222, with no mixed frame.
- With LEADING_ZERO_BLANK_EN: 16'h0070 → digits 3,2 give seg_o=0, digit1=1110000, digit0=1111110. 16'h0000 → only digit0 lit.
- Reset while pending=1 → display stays 0000, ready_o=1, and the pending value never appears.
